// File: rtl/clk_freq_monitor_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clk_freq_monitor_pkg
//  Description : Shared types, default constants and the window range check
//                for the PLL clock frequency monitor.
//  Revision    : 1.0  initial release
// ============================================================================
package clk_freq_monitor_pkg;

    // Lock-status FSM encoding
    typedef enum logic [0:0] {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } lock_state_t;

    // Defaults for a 24 MHz reference watching clkoutd/64 of a 33.33 MHz PLL
    localparam int unsigned DEF_GATE_CYCLES  = 24000;
    localparam int unsigned DEF_EXP_COUNT    = 521;
    localparam int unsigned DEF_TOL          = 4;
    localparam int unsigned DEF_LOCK_WINDOWS = 4;
    localparam int unsigned DEF_LOSS_WINDOWS = 2;
    localparam int unsigned DEF_SYNC_STAGES  = 2;
    localparam int unsigned DEF_CNT_W        = 16;

    // Range compare width: wide enough for any CNT_W up to 32 plus one
    // headroom bit, so EXP_COUNT+TOL can never wrap.
    localparam int RANGE_W = 33;

    // Inclusive window check; the lower bound clamps at zero.
    function automatic logic range_ok(
        input logic [RANGE_W-1:0] cnt,
        input logic [RANGE_W-1:0] exp_cnt,
        input logic [RANGE_W-1:0] tol
    );
        logic [RANGE_W-1:0] lo;
        logic [RANGE_W-1:0] hi;
        lo = (exp_cnt > tol) ? (exp_cnt - tol) : '0;
        hi = exp_cnt + tol;
        return (cnt >= lo) && (cnt <= hi);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mon_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : mon_sync_edge
//  Description : Multi-flop synchroniser for an asynchronous input followed
//                by a history flop; emits a one-cycle pulse per rising edge.
//  Revision    : 1.0  initial release
// ============================================================================
module mon_sync_edge
    import clk_freq_monitor_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    // Synchroniser chain plus one history stage for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule
`default_nettype wire

// File: rtl/clk_freq_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : clk_freq_monitor
//  Description : Counts rising edges of a divided PLL clock over a fixed gate
//                window of the reference clock, checks each count against an
//                expected value +/- tolerance and runs a hysteresis lock FSM.
//                Optional macro CLK_MON_STICKY_ERR_EN adds a sticky error flag
//                (err_sticky) with a clear input (err_clr).
//  Revision    : 1.0  initial release
// ============================================================================
module clk_freq_monitor
    import clk_freq_monitor_pkg::*;
#(
    parameter int unsigned GATE_CYCLES  = DEF_GATE_CYCLES,
    parameter int unsigned EXP_COUNT    = DEF_EXP_COUNT,
    parameter int unsigned TOL          = DEF_TOL,
    parameter int unsigned LOCK_WINDOWS = DEF_LOCK_WINDOWS,
    parameter int unsigned LOSS_WINDOWS = DEF_LOSS_WINDOWS,
    parameter int unsigned SYNC_STAGES  = DEF_SYNC_STAGES,
    parameter int unsigned CNT_W        = DEF_CNT_W
) (
    input  logic             clkin,
    input  logic             reset,
    input  logic             mon_in,
`ifdef CLK_MON_STICKY_ERR_EN
    input  logic             err_clr,
    output logic             err_sticky,
`endif
    output logic [CNT_W-1:0] freq_count,
    output logic             meas_valid,
    output logic             in_range,
    output logic             locked,
    output logic             lock_lost
);

    localparam int GATE_W   = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam int WIN_MAX  = (LOCK_WINDOWS > LOSS_WINDOWS) ? LOCK_WINDOWS : LOSS_WINDOWS;
    localparam int WIN_W    = $clog2(WIN_MAX + 1);

    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [WIN_W-1:0]  LOCK_TGT  = WIN_W'(LOCK_WINDOWS);
    localparam logic [WIN_W-1:0]  LOSS_TGT  = WIN_W'(LOSS_WINDOWS);

    logic              rise;
    logic [GATE_W-1:0] gate_cnt;
    logic [CNT_W-1:0]  edge_cnt;
    logic              first_win;
    logic              terminal;
    logic              win_done;
    logic [CNT_W-1:0]  win_total;
    logic              win_ok;

    lock_state_t       state;
    lock_state_t       state_nxt;
    logic [WIN_W-1:0]  good_cnt;
    logic [WIN_W-1:0]  good_nxt;
    logic [WIN_W-1:0]  bad_cnt;
    logic [WIN_W-1:0]  bad_nxt;
    logic              lost_nxt;

    mon_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (clkin),
        .rst      (reset),
        .async_in (mon_in),
        .rise     (rise)
    );

    // Window bookkeeping. An edge seen on the terminal cycle still belongs
    // to the closing window, so the total includes this cycle's edge.
    assign terminal  = (gate_cnt == GATE_LAST);
    assign win_done  = terminal & ~first_win;
    assign win_total = (rise && (edge_cnt != CNT_MAX)) ? edge_cnt + 1'b1 : edge_cnt;
    assign win_ok    = range_ok(RANGE_W'(win_total), RANGE_W'(EXP_COUNT), RANGE_W'(TOL));

    // Free-running gate counter 0..GATE_CYCLES-1
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            gate_cnt <= '0;
        end else if (terminal) begin
            gate_cnt <= '0;
        end else begin
            gate_cnt <= gate_cnt + 1'b1;
        end
    end

    // Saturating edge counter, restarted after each terminal cycle
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            edge_cnt <= '0;
        end else if (terminal) begin
            edge_cnt <= '0;
        end else if (rise && (edge_cnt != CNT_MAX)) begin
            edge_cnt <= edge_cnt + 1'b1;
        end
    end

    // The first window after reset may contain a spurious synchroniser edge
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            first_win <= 1'b1;
        end else if (terminal) begin
            first_win <= 1'b0;
        end
    end

    // Publish the window result in the cycle after the terminal cycle
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            meas_valid <= 1'b0;
            freq_count <= '0;
            in_range   <= 1'b0;
        end else begin
            meas_valid <= win_done;
            if (win_done) begin
                freq_count <= win_total;
                in_range   <= win_ok;
            end
        end
    end

    // FSM state register with its window counters and loss pulse
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            state     <= ST_UNLOCKED;
            good_cnt  <= '0;
            bad_cnt   <= '0;
            lock_lost <= 1'b0;
        end else begin
            state     <= state_nxt;
            good_cnt  <= good_nxt;
            bad_cnt   <= bad_nxt;
            lock_lost <= lost_nxt;
        end
    end

    // FSM next state: only a completed (non-discarded) window moves it
    always_comb begin
        state_nxt = state;
        good_nxt  = good_cnt;
        bad_nxt   = bad_cnt;
        lost_nxt  = 1'b0;
        if (win_done) begin
            case (state)
                ST_UNLOCKED: begin
                    if (win_ok) begin
                        if ((good_cnt + 1'b1) == LOCK_TGT) begin
                            state_nxt = ST_LOCKED;
                            good_nxt  = '0;
                            bad_nxt   = '0;
                        end else begin
                            good_nxt = good_cnt + 1'b1;
                        end
                    end else begin
                        good_nxt = '0;
                    end
                end
                ST_LOCKED: begin
                    if (!win_ok) begin
                        if ((bad_cnt + 1'b1) == LOSS_TGT) begin
                            state_nxt = ST_UNLOCKED;
                            bad_nxt   = '0;
                            good_nxt  = '0;
                            lost_nxt  = 1'b1;
                        end else begin
                            bad_nxt = bad_cnt + 1'b1;
                        end
                    end else begin
                        bad_nxt = '0;
                    end
                end
                default: begin
                    state_nxt = ST_UNLOCKED;
                    good_nxt  = '0;
                    bad_nxt   = '0;
                end
            endcase
        end
    end

    // FSM outputs: lock status follows the state directly
    always_comb begin
        locked = (state == ST_LOCKED);
    end

`ifdef CLK_MON_STICKY_ERR_EN
    logic err_set;

    // Any out-of-range window while locked (which includes every lock loss)
    assign err_set = (win_done & (state == ST_LOCKED) & ~win_ok) | lost_nxt;

    // Sticky error flag; a simultaneous set beats the clear
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            err_sticky <= 1'b0;
        end else if (err_set) begin
            err_sticky <= 1'b1;
        end else if (err_clr) begin
            err_sticky <= 1'b0;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_clk_freq_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clk_freq_monitor
//  Description : Directed self-checking bench for clk_freq_monitor with a
//                1000-cycle gate, expected count 50, tolerance 2.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_clk_freq_monitor;

    localparam int G     = 1000;
    localparam int EXP   = 50;
    localparam int TOLV  = 2;
    localparam int CW    = 16;

    logic          clkin  = 1'b0;
    logic          reset  = 1'b1;
    logic          mon_in = 1'b0;
    logic [CW-1:0] freq_count;
    logic          meas_valid;
    logic          in_range;
    logic          locked;
    logic          lock_lost;
`ifdef CLK_MON_STICKY_ERR_EN
    logic          err_clr = 1'b0;
    logic          err_sticky;
`endif

    clk_freq_monitor #(
        .GATE_CYCLES  (G),
        .EXP_COUNT    (EXP),
        .TOL          (TOLV),
        .LOCK_WINDOWS (3),
        .LOSS_WINDOWS (2),
        .SYNC_STAGES  (2),
        .CNT_W        (CW)
    ) dut (
        .clkin      (clkin),
        .reset      (reset),
        .mon_in     (mon_in),
`ifdef CLK_MON_STICKY_ERR_EN
        .err_clr    (err_clr),
        .err_sticky (err_sticky),
`endif
        .freq_count (freq_count),
        .meas_valid (meas_valid),
        .in_range   (in_range),
        .locked     (locked),
        .lock_lost  (lock_lost)
    );

    always #5 clkin = ~clkin;

    int cyc       = 0;   // equals the DUT gate position modulo G
    int gen_mode  = 0;   // 0: exact edge pattern, 1: periodic square wave
    int period    = 20;
    int edges_n   = 0;
    bit term_edge = 1'b0;
    int n_pass    = 0;
    int n_total   = 0;

    // Reference cycle counter, cleared while reset is held
    initial begin
        forever begin
            @(posedge clkin);
            if (reset) cyc = 0;
            else       cyc = cyc + 1;
        end
    end

    // Level for mon_in when driven in cycle c. A rise driven here reaches the
    // DUT edge detector two cycles later, at gate position h = (c+2) mod G.
    // Every mode drives low at gate 0 so modes can switch right after meas.
    function automatic logic gen_level(input int c);
        int h;
        h = (c + 2) % G;
        if (gen_mode == 1) return ((c % period) >= (period / 2));
        if (term_edge && (h == G - 1)) return 1'b1;
        return (h >= 5) && (((h - 5) % 10) < 5) && (((h - 5) / 10) < edges_n);
    endfunction

    initial begin
        forever begin
            @(negedge clkin);
            mon_in = gen_level(cyc);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(negedge clkin);
        reset = 1'b0;
    endtask

    task automatic wait_meas(input string tag);
        int k;
        k = 0;
        @(negedge clkin);
        while ((meas_valid !== 1'b1) && (k < 2500)) begin
            @(negedge clkin);
            k++;
        end
        if (meas_valid !== 1'b1) begin
            n_total++;
            $display("FAIL %s: meas_valid not seen, got %b want 1", tag, meas_valid);
        end
    endtask

    task automatic wait_gate(input int g);
        int k;
        k = 0;
        @(negedge clkin);
        while (((cyc % G) != g) && (k < 1200)) begin
            @(negedge clkin);
            k++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clkin);
        n_total++;
        if ({freq_count, meas_valid, in_range, locked, lock_lost} !== '0)
            $display("FAIL reset_outputs: got %h want 0",
                     {freq_count, meas_valid, in_range, locked, lock_lost});
        else n_pass++;
    endtask

    task automatic test_lock_acquire();
        gen_mode = 1; period = 20;
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            wait_meas("acq");
            if (i == 1) begin
                n_total++;
                if (cyc !== 2000) $display("FAIL acq_first_meas_cycle: got %0d want 2000", cyc);
                else n_pass++;
            end
            n_total++;
            if (freq_count !== 16'd50) $display("FAIL acq_count[%0d]: got %0d want 50", i, freq_count);
            else n_pass++;
            n_total++;
            if (in_range !== 1'b1) $display("FAIL acq_in_range[%0d]: got %b want 1", i, in_range);
            else n_pass++;
            n_total++;
            if (locked !== (i >= 3)) $display("FAIL acq_locked[%0d]: got %b want %b", i, locked, (i >= 3));
            else n_pass++;
        end
    endtask

    task automatic test_off_freq();
        gen_mode = 1; period = 25;
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            wait_meas("off");
            n_total++;
            if (freq_count !== 16'd40) $display("FAIL off_count[%0d]: got %0d want 40", i, freq_count);
            else n_pass++;
            n_total++;
            if ({in_range, locked} !== 2'b00) $display("FAIL off_range_lock[%0d]: got %b want 00", i, {in_range, locked});
            else n_pass++;
        end
    endtask

    task automatic test_tolerance();
        int n_tab[6]  = '{48, 52, 47, 53, 47, 52};
        bit t_tab[6]  = '{0, 0, 0, 0, 1, 0};
        int e_tab[6]  = '{48, 52, 47, 53, 48, 52};
        bit r_tab[6]  = '{1, 1, 0, 0, 1, 1};
        gen_mode = 0; edges_n = n_tab[0]; term_edge = t_tab[0];
        do_reset();
        for (int i = 0; i < 6; i++) begin
            wait_meas("tol");
            n_total++;
            if (freq_count !== CW'(e_tab[i])) $display("FAIL tol_count[%0d]: got %0d want %0d", i, freq_count, e_tab[i]);
            else n_pass++;
            n_total++;
            if (in_range !== r_tab[i]) $display("FAIL tol_in_range[%0d]: got %b want %b", i, in_range, r_tab[i]);
            else n_pass++;
            if (i < 5) begin
                edges_n   = n_tab[i + 1];
                term_edge = t_tab[i + 1];
            end
        end
        term_edge = 1'b0;
    endtask

    task automatic test_loss();
        gen_mode = 1; period = 20;
        do_reset();
        repeat (3) wait_meas("loss_lock");
        n_total++;
        if (locked !== 1'b1) $display("FAIL loss_pre_locked: got %b want 1", locked);
        else n_pass++;
        gen_mode = 0; edges_n = 0;
        wait_meas("loss1");
        n_total++;
        if ({freq_count, in_range, locked, lock_lost} !== {16'd0, 1'b0, 1'b1, 1'b0})
            $display("FAIL loss_first_bad: got cnt=%0d rng=%b lck=%b lost=%b want 0 0 1 0",
                     freq_count, in_range, locked, lock_lost);
        else n_pass++;
        wait_meas("loss2");
        n_total++;
        if ({freq_count, meas_valid, locked, lock_lost} !== {16'd0, 1'b1, 1'b0, 1'b1})
            $display("FAIL loss_drop: got cnt=%0d mv=%b lck=%b lost=%b want 0 1 0 1",
                     freq_count, meas_valid, locked, lock_lost);
        else n_pass++;
        @(negedge clkin);
        n_total++;
        if ({locked, lock_lost} !== 2'b00) $display("FAIL loss_pulse_end: got %b want 00", {locked, lock_lost});
        else n_pass++;
    endtask

    task automatic test_hysteresis_reset();
        gen_mode = 1; period = 20;
        do_reset();
        repeat (3) wait_meas("hys_lock");
        for (int i = 0; i < 4; i++) begin
            if ((i % 2) == 0) begin gen_mode = 0; edges_n = 40; end
            else gen_mode = 1;
            wait_meas("hys");
            n_total++;
            if ({in_range, locked} !== {((i % 2) == 1), 1'b1})
                $display("FAIL hys_win[%0d]: got rng=%b lck=%b want %b 1", i, in_range, locked, ((i % 2) == 1));
            else n_pass++;
        end
        wait_gate(500);
        reset = 1'b1;
        #1;
        n_total++;
        if ({freq_count, meas_valid, in_range, locked, lock_lost} !== '0)
            $display("FAIL midreset_outputs: got %h want 0",
                     {freq_count, meas_valid, in_range, locked, lock_lost});
        else n_pass++;
        repeat (2) @(negedge clkin);
        reset = 1'b0;
        wait_meas("post_reset");
        n_total++;
        if (cyc !== 2000) $display("FAIL post_reset_latency: got %0d want 2000", cyc);
        else n_pass++;
        n_total++;
        if (freq_count !== 16'd50) $display("FAIL post_reset_count: got %0d want 50", freq_count);
        else n_pass++;
    endtask

`ifdef CLK_MON_STICKY_ERR_EN
    task automatic test_sticky();
        gen_mode = 1; period = 20;
        do_reset();
        repeat (3) wait_meas("stk_lock");
        n_total++;
        if ({locked, err_sticky} !== 2'b10) $display("FAIL stk_initial: got %b want 10", {locked, err_sticky});
        else n_pass++;
        gen_mode = 0; edges_n = 40;
        wait_meas("stk_bad1");
        n_total++;
        if (err_sticky !== 1'b1) $display("FAIL stk_set: got %b want 1", err_sticky);
        else n_pass++;
        gen_mode = 1;
        wait_meas("stk_good");
        gen_mode = 0; edges_n = 40;
        wait_gate(G - 1);
        err_clr = 1'b1;
        @(negedge clkin);
        n_total++;
        if ({meas_valid, err_sticky} !== 2'b11) $display("FAIL stk_set_wins: got %b want 11", {meas_valid, err_sticky});
        else n_pass++;
        err_clr = 1'b0;
        gen_mode = 1;
        wait_gate(300);
        err_clr = 1'b1;
        @(negedge clkin);
        err_clr = 1'b0;
        n_total++;
        if (err_sticky !== 1'b0) $display("FAIL stk_clear: got %b want 0", err_sticky);
        else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_lock_acquire();
        test_off_freq();
        test_tolerance();
        test_loss();
        test_hysteresis_reset();
`ifdef CLK_MON_STICKY_ERR_EN
        test_sticky();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/clk_freq_monitor.md
Name: clk_freq_monitor

Overview:
Checks the PLL-derived clock from the 24 MHz input-clock domain. It measures a slow divided copy of the PLL output (mon_in, e.g. clkoutd/64 toggled in its own domain) by counting its rising edges over a fixed gate window. Each count is compared against an expected value and tolerance. A window-based hysteresis FSM raises a lock status that LCD timing logic uses to hold off display start.

Parameters:
GATE_CYCLES, 24000, clkin cycles per measurement window (1 ms at 24 MHz)
EXP_COUNT, 521, expected mon_in rising edges per window (33.33 MHz / 64 over 1 ms)
TOL, 4, allowed +/- deviation from EXP_COUNT, inclusive
LOCK_WINDOWS, 4, consecutive in-range windows needed to declare locked
LOSS_WINDOWS, 2, consecutive out-of-range windows needed to drop lock
SYNC_STAGES, 2, synchroniser depth for mon_in (>=2)
CNT_W, 16, width of the edge counter and of freq_count

Ports:
clkin  input  1  system clock, 24 MHz
reset  input  1  asynchronous, active-high reset
mon_in  input  1  asynchronous monitored square wave
freq_count  output  CNT_W  edge count of the last completed window
meas_valid  output  1  one-cycle pulse: freq_count/in_range updated
in_range  output  1  last window within [EXP_COUNT-TOL, EXP_COUNT+TOL]
locked  output  1  lock status
lock_lost  output  1  one-cycle pulse on LOCKED->UNLOCKED

Behaviour:
- Reset (async assert, sync release): all outputs 0, counters 0, synchroniser 0, FSM UNLOCKED, first-window flag set.
- mon_in passes through SYNC_STAGES flops, then one history flop. Rising edge = sync & ~hist.
- Gate counter runs 0..GATE_CYCLES-1 and wraps. Terminal cycle = count GATE_CYCLES-1.
- Edge counter increments per edge and saturates at 2^CNT_W-1.
- An edge on the terminal cycle belongs to the closing window.
- Edge counter restarts at 0 on the cycle after the terminal cycle.
- On the cycle after terminal: freq_count latches the window total, in_range is computed, and meas_valid pulses for 1 cycle.
  - Lower bound is EXP_COUNT-TOL, clamped at 0.
  - Compare is unsigned, CNT_W+1 bits, to avoid overflow.
- First window after reset is discarded (guards against a spurious synchroniser edge): no meas_valid, no FSM update, outputs stay 0.
- FSM, evaluated only in the meas_valid cycle:
  - UNLOCKED: in-range increments good_cnt, out-of-range clears it. When good_cnt reaches LOCK_WINDOWS, go to LOCKED; locked=1 in that same cycle; good_cnt cleared.
  - LOCKED: out-of-range increments bad_cnt, in-range clears it. When bad_cnt reaches LOSS_WINDOWS, go to UNLOCKED; locked=0 and lock_lost=1 in that same cycle; bad_cnt cleared.
- Stopped or absent mon_in gives count 0, which is out of range, so lock is lost after LOSS_WINDOWS windows.
- Reset mid-window aborts the window. Measurement restarts from gate count 0 after release.

Optional Feature:
Macro CLK_MON_STICKY_ERR_EN.
- Defined: adds input err_clr (1 bit) and output err_sticky (1 bit, reset 0).
  - err_sticky sets on any lock_lost pulse and on any out-of-range window while locked.
  - err_clr clears it.
  - If set and clear occur in the same cycle, set wins.
- Undefined: the ports and logic are absent. Behaviour is otherwise identical.

Decomposition:
- Package clk_freq_monitor_pkg holds:
  - FSM state typedef (ST_UNLOCKED, ST_LOCKED);
  - default constants for the 24 MHz / clkoutd/64 configuration;
  - a range-check function.
- Sub-module mon_sync_edge: SYNC_STAGES synchroniser plus history flop, output is a one-cycle rise pulse. It is reused by other async-input blocks.

Test Plan:
Bench parameters for all cases: GATE_CYCLES=1000, EXP_COUNT=50, TOL=2, LOCK_WINDOWS=3, LOSS_WINDOWS=2.
- Lock acquire: mon_in period 20 clkin -> from window 2 on, freq_count=50 and in_range=1. locked rises in the meas_valid cycle of window 4 (3rd counted window) and stays 1.
- Off-frequency: period 25 -> freq_count=40, in_range=0 every window, locked never asserts.
- Tolerance edges: bench drives exactly 48/52 edges -> in_range=1; 47/53 edges -> in_range=0. An edge placed on the terminal cycle is counted in the closing window.
- Loss: lock, then hold mon_in low -> windows give 0, 0. On the 2nd, locked falls and lock_lost pulses once, in the same cycle as meas_valid.
- Hysteresis and reset: while locked, one bad window then good windows -> locked stays 1. Assert reset at gate count 500 -> all outputs 0 at once. After release the first meas_valid occurs 2000 cycles later.
- Macro on: a bad window while locked sets err_sticky; err_clr asserted together with a new error leaves err_sticky=1; err_clr alone clears it.
